uart_count_host: RTL
====================

# uart_count_host

Host-side initiator for the UART counter protocol. It accepts local "reset" and "next" commands and transmits them as the ASCII bytes 'r' and 'n'. It then receives the variable-length ASCII decimal reply, converts it to binary, and checks it against an internal model of the responder's counter. It sits opposite the counting responder on the same serial link and reuses the existing uart_tx and uart_rx blocks.

## Interface
- CLKS_PER_BIT, default 2: clocks per UART bit. Passed to both uart_tx and uart_rx.
- CNT_MAX, default 17: the responder's wrap value. Legal range 1..99.
- MAX_DIGITS, default derived: number of decimal digits in CNT_MAX (1 or 2).
- GAP_BITS, default 20: idle bit-times that end a reply. GAP_CLKS = GAP_BITS*CLKS_PER_BIT.
- RESP_TIMEOUT_CLKS, default 256: clocks allowed from end of command transmission to the first reply byte.
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- i_cmd_valid  in  1  command request.
- i_cmd  in  1  0 = reset ('r'), 1 = next ('n').
- o_cmd_ready  out  1  high only in IDLE.
- rx_phy  in  1  serial line from the responder.
- tx_phy  out  1  serial line to the responder. Idles high.
- o_resp_valid  out  1  one-cycle pulse when a transaction completes.
- o_resp_value  out  8  binary value of the received digits. Held until the next pulse.
- o_resp_ok  out  1  qualified by o_resp_valid: no error and value equals the expected value.
- o_err_timeout  out  1  qualified by o_resp_valid: no reply byte arrived.
- o_err_char  out  1  qualified by o_resp_valid: a byte outside '0'..'9' was received.
- o_busy  out  1  high whenever the state is not IDLE.
- o_expected  out  8  current model value, i.e. what the next 'n' should return.

## Operation
- States: IDLE, SEND, WAIT_TX, WAIT_FIRST, RECV, DONE.
- IDLE
  - Commands are accepted when i_cmd_valid && o_cmd_ready.
  - The command is latched and the state goes to SEND.
  - rx bytes arriving in IDLE are discarded.
- SEND
  - Waits while uart_tx o_tx_busy is high.
  - Then drives i_tx_valid for exactly one cycle with data 'r' (0x72) or 'n' (0x6E), and goes to WAIT_TX.
- WAIT_TX
  - Waits for o_tx_busy to rise and then fall.
  - Clears the accumulator, digit count and error flags, loads the timeout counter, and goes to WAIT_FIRST.
- WAIT_FIRST
  - The timeout counter decrements each clock.
  - On rx_valid the byte is processed and the state goes to RECV.
  - If the counter reaches 0 first, the timeout flag is set and the state goes to DONE.
- RECV
  - The gap counter reloads to GAP_CLKS on every rx_valid and while rx_busy is high; otherwise it decrements.
  - Go to DONE when the gap counter reaches 0, or on the cycle after the digit count reaches MAX_DIGITS.
- Byte processing
  - If the byte is in '0'..'9': acc = acc*10 + (byte - 0x30), 8-bit saturating at 255, and digit count increments.
  - Otherwise the char-error flag is set, acc is unchanged, and the byte still counts toward MAX_DIGITS.
- DONE
  - Pulses o_resp_valid and updates the model, then returns to IDLE.
  - o_resp_value = acc (0 on timeout).
  - o_resp_ok = !timeout && !char_err && acc == exp.
- Model update in DONE, applied even when the transaction had an error:
  - After 'r': exp = 1.
  - After 'n': exp = (exp == CNT_MAX) ? 0 : exp + 1.
- Check value
  - For 'r' the reply is compared against 0.
  - For 'n' the reply is compared against the pre-update exp.
- Reset
  - All registers clear: state IDLE, exp 0, counters 0, o_resp_value 0.
  - All pulse and error outputs go to 0, o_cmd_ready goes to 1, tx_phy idles high.
  - Reset mid-transaction aborts it with no o_resp_valid pulse. uart_tx and uart_rx share rst.

## Timing
- Command accepted at edge N: o_busy and !o_cmd_ready from N+1. uart_tx i_tx_valid is asserted no earlier than N+1.
- One command per transaction. No pipelining; a new command is accepted only in IDLE.
- o_resp_valid occurs exactly one cycle after DONE is entered; o_cmd_ready rises the following cycle.
- For an n-digit reply where n < MAX_DIGITS, o_resp_valid comes GAP_CLKS+1 to GAP_CLKS+2 clocks after the last rx_valid.
- i_cmd_valid while busy is ignored and never queued.

## Test plan
- Reset, then 'n' with the loopback responder model → reply "0". Expect o_resp_value=0, o_resp_ok=1, o_expected=1.
- Reset, then 'r' followed by 12 'n' commands → the last reply is "12" (0x31,0x32). Expect o_resp_value=12, ok=1, tx bytes 0x72 then 0x6E.
- Wrap: issue 'n' until the reply is 17, then one more 'n' → reply "0". Expect o_resp_value=0, ok=1, o_expected=1.
- Responder silent, issue 'n' → expect o_resp_valid with o_err_timeout=1, ok=0, value 0, exactly RESP_TIMEOUT_CLKS after tx completes.
- Responder returns "5" while exp=3 → value=5, ok=0, no errors. Responder returns 'x' → o_err_char=1, ok=0.
- Assert rst during RECV after the first digit → no o_resp_valid, o_expected=0, o_cmd_ready=1 on the next cycle.

Source files
------------

// File: rtl/uart_count_host.sv
// Host side of the UART counter protocol: sends 'r'/'n', parses the decimal reply,
// and checks it against a local model of the responder's counter.
module uart_tx #(
  parameter int CLKS_PER_BIT = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       i_tx_valid,
  input  logic [7:0] i_tx_data,
  output logic       o_tx_busy,
  output logic       o_tx
);
  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] CPB_M1 = CW'(CLKS_PER_BIT - 1);

  logic [9:0]    shreg;
  logic [3:0]    bit_cnt;
  logic [CW-1:0] clk_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      shreg     <= '1;
      bit_cnt   <= '0;
      clk_cnt   <= '0;
      o_tx_busy <= 1'b0;
      o_tx      <= 1'b1;
    end else if (!o_tx_busy) begin
      if (i_tx_valid) begin
        shreg     <= {1'b1, i_tx_data, 1'b0};
        o_tx      <= 1'b0;
        o_tx_busy <= 1'b1;
        clk_cnt   <= CPB_M1;
        bit_cnt   <= '0;
      end
    end else if (clk_cnt != '0) begin
      clk_cnt <= clk_cnt - 1'b1;
    end else begin
      clk_cnt <= CPB_M1;
      if (bit_cnt == 4'd9) begin
        o_tx_busy <= 1'b0;
        o_tx      <= 1'b1;
      end else begin
        bit_cnt <= bit_cnt + 4'd1;
        o_tx    <= shreg[1];
        shreg   <= {1'b1, shreg[9:1]};
      end
    end
  end
endmodule

module uart_rx #(
  parameter int CLKS_PER_BIT = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       i_rx,
  output logic       o_rx_valid,
  output logic [7:0] o_rx_data,
  output logic       o_rx_busy
);
  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] CPB_M1 = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF   = CW'((CLKS_PER_BIT - 1) / 2);

  logic          rx_s1, rx_s2;
  logic [7:0]    shreg;
  logic [3:0]    bit_idx;
  logic [CW-1:0] clk_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      rx_s1      <= 1'b1;
      rx_s2      <= 1'b1;
      shreg      <= '0;
      bit_idx    <= '0;
      clk_cnt    <= '0;
      o_rx_busy  <= 1'b0;
      o_rx_valid <= 1'b0;
      o_rx_data  <= '0;
    end else begin
      rx_s1      <= i_rx;
      rx_s2      <= rx_s1;
      o_rx_valid <= 1'b0;
      if (!o_rx_busy) begin
        if (!rx_s2) begin
          o_rx_busy <= 1'b1;
          clk_cnt   <= HALF;
          bit_idx   <= '0;
        end
      end else if (clk_cnt != '0) begin
        clk_cnt <= clk_cnt - 1'b1;
      end else begin
        clk_cnt <= CPB_M1;
        // bit_idx: 0 = start, 1..8 = data LSB first, 9 = stop
        if (bit_idx == 4'd0) begin
          if (rx_s2) o_rx_busy <= 1'b0;
          else       bit_idx   <= 4'd1;
        end else if (bit_idx <= 4'd8) begin
          shreg   <= {rx_s2, shreg[7:1]};
          bit_idx <= bit_idx + 4'd1;
        end else begin
          o_rx_busy <= 1'b0;
          if (rx_s2) begin
            o_rx_valid <= 1'b1;
            o_rx_data  <= shreg;
          end
        end
      end
    end
  end
endmodule

// state      | meaning
// IDLE       | ready for a command, rx traffic ignored
// SEND       | waiting for uart_tx to be free, then launch the command byte
// WAIT_TX    | command byte on the wire
// WAIT_FIRST | timeout window for the first reply byte
// RECV       | collecting digits until the line goes quiet or MAX_DIGITS bytes
// DONE       | report result and advance the counter model
module uart_count_host #(
  parameter int CLKS_PER_BIT      = 2,
  parameter int CNT_MAX           = 17,
  parameter int MAX_DIGITS        = (CNT_MAX >= 10) ? 2 : 1,
  parameter int GAP_BITS          = 20,
  parameter int RESP_TIMEOUT_CLKS = 256
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       i_cmd_valid,
  input  logic       i_cmd,
  output logic       o_cmd_ready,
  input  logic       rx_phy,
  output logic       tx_phy,
  output logic       o_resp_valid,
  output logic [7:0] o_resp_value,
  output logic       o_resp_ok,
  output logic       o_err_timeout,
  output logic       o_err_char,
  output logic       o_busy,
  output logic [7:0] o_expected
);
  localparam int GAP_CLKS = GAP_BITS * CLKS_PER_BIT;
  localparam logic [15:0] GAP_LOAD = 16'(GAP_CLKS);
  // Loaded two short so o_resp_valid lands exactly RESP_TIMEOUT_CLKS after tx_busy falls
  localparam logic [15:0] TO_LOAD  = 16'(RESP_TIMEOUT_CLKS - 2);
  localparam logic [1:0]  MAXD     = 2'(MAX_DIGITS);
  localparam logic [7:0]  CNT_TOP  = 8'(CNT_MAX);

  localparam logic [2:0] S_IDLE       = 3'd0;
  localparam logic [2:0] S_SEND       = 3'd1;
  localparam logic [2:0] S_WAIT_TX    = 3'd2;
  localparam logic [2:0] S_WAIT_FIRST = 3'd3;
  localparam logic [2:0] S_RECV       = 3'd4;
  localparam logic [2:0] S_DONE       = 3'd5;

  logic [2:0]  state;
  logic        cmd_q, tx_valid, tx_busy, tx_seen;
  logic        rx_valid, rx_busy;
  logic [7:0]  tx_data, rx_data, acc, exp_q, chk_val;
  logic [1:0]  dig_cnt;
  logic        tmo, cerr, is_digit;
  logic [15:0] tcnt, gcnt;
  logic [11:0] acc_sum;
  logic [7:0]  acc_next;

  assign tx_data     = cmd_q ? 8'h6E : 8'h72;
  assign o_cmd_ready = (state == S_IDLE);
  assign o_busy      = (state != S_IDLE);
  assign o_expected  = exp_q;
  assign chk_val     = cmd_q ? exp_q : 8'd0;

  always_comb begin
    is_digit = (rx_data >= 8'h30) && (rx_data <= 8'h39);
    acc_sum  = 12'(acc) * 12'd10 + 12'(rx_data - 8'h30);
    acc_next = (acc_sum > 12'd255) ? 8'hFF : acc_sum[7:0];
  end

  uart_tx #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_tx (
    .clk(clk), .rst(rst), .i_tx_valid(tx_valid), .i_tx_data(tx_data),
    .o_tx_busy(tx_busy), .o_tx(tx_phy)
  );

  uart_rx #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_rx (
    .clk(clk), .rst(rst), .i_rx(rx_phy), .o_rx_valid(rx_valid),
    .o_rx_data(rx_data), .o_rx_busy(rx_busy)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= S_IDLE;
      cmd_q         <= 1'b0;
      tx_valid      <= 1'b0;
      tx_seen       <= 1'b0;
      acc           <= '0;
      dig_cnt       <= '0;
      tmo           <= 1'b0;
      cerr          <= 1'b0;
      tcnt          <= '0;
      gcnt          <= '0;
      exp_q         <= '0;
      o_resp_valid  <= 1'b0;
      o_resp_value  <= '0;
      o_resp_ok     <= 1'b0;
      o_err_timeout <= 1'b0;
      o_err_char    <= 1'b0;
    end else begin
      tx_valid     <= 1'b0;
      o_resp_valid <= 1'b0;
      case (state)
        S_IDLE: begin
          if (i_cmd_valid) begin
            cmd_q <= i_cmd;
            state <= S_SEND;
          end
        end
        S_SEND: begin
          if (!tx_busy) begin
            tx_valid <= 1'b1;
            tx_seen  <= 1'b0;
            state    <= S_WAIT_TX;
          end
        end
        S_WAIT_TX: begin
          if (tx_busy) begin
            tx_seen <= 1'b1;
          end else if (tx_seen) begin
            acc     <= '0;
            dig_cnt <= '0;
            tmo     <= 1'b0;
            cerr    <= 1'b0;
            tcnt    <= TO_LOAD;
            state   <= S_WAIT_FIRST;
          end
        end
        S_WAIT_FIRST: begin
          if (rx_valid) begin
            if (is_digit) acc <= acc_next;
            else          cerr <= 1'b1;
            dig_cnt <= dig_cnt + 2'd1;
            gcnt    <= GAP_LOAD;
            state   <= S_RECV;
          end else if (tcnt <= 16'd1) begin
            tcnt  <= '0;
            tmo   <= 1'b1;
            state <= S_DONE;
          end else begin
            tcnt <= tcnt - 16'd1;
          end
        end
        S_RECV: begin
          if (dig_cnt == MAXD) begin
            state <= S_DONE;
          end else if (rx_valid) begin
            if (is_digit) acc <= acc_next;
            else          cerr <= 1'b1;
            dig_cnt <= dig_cnt + 2'd1;
            gcnt    <= GAP_LOAD;
          end else if (rx_busy) begin
            gcnt <= GAP_LOAD;
          end else if (gcnt <= 16'd1) begin
            gcnt  <= '0;
            state <= S_DONE;
          end else begin
            gcnt <= gcnt - 16'd1;
          end
        end
        S_DONE: begin
          // First cycle reports; second cycle releases to IDLE so ready trails the pulse
          if (!o_resp_valid) begin
            o_resp_valid  <= 1'b1;
            o_resp_value  <= tmo ? 8'd0 : acc;
            o_resp_ok     <= !tmo && !cerr && (acc == chk_val);
            o_err_timeout <= tmo;
            o_err_char    <= cerr;
            if (!cmd_q)                exp_q <= 8'd1;
            else if (exp_q == CNT_TOP) exp_q <= 8'd0;
            else                       exp_q <= exp_q + 8'd1;
          end else begin
            state <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule
